// File: rtl/hbm_auto_write.sv
// AXI4 write master for one HBM pseudo-channel: issues write_ops strided bursts, streams upstream
// data onto W and pulses done after the last B. Optional BRESP error flag: HBM_AUTO_WRITE_ERR_CHECK_EN.
`timescale 1ns/1ps
module hbm_auto_write #(
  parameter int ENGINE_ID       = 0,
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_write,
  input  logic [31:0]               write_ops,
  input  logic [31:0]               stride,
  input  logic [ADDR_WIDTH-1:0]     init_addr,
  input  logic [15:0]               mem_burst_size,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      up_vld,
  output logic                      up_rdy,
  input  logic [DATA_WIDTH-1:0]     up_dat,
  output logic                      m_axi_AWVALID,
  output logic [ADDR_WIDTH-1:0]     m_axi_AWADDR,
  output logic [ID_WIDTH-1:0]       m_axi_AWID,
  output logic [7:0]                m_axi_AWLEN,
  output logic [2:0]                m_axi_AWSIZE,
  output logic [1:0]                m_axi_AWBURST,
  output logic                      m_axi_AWLOCK,
  output logic [3:0]                m_axi_AWCACHE,
  output logic [2:0]                m_axi_AWPROT,
  output logic [3:0]                m_axi_AWQOS,
  output logic [3:0]                m_axi_AWREGION,
  input  logic                      m_axi_AWREADY,
  output logic                      m_axi_WVALID,
  output logic [DATA_WIDTH-1:0]     m_axi_WDATA,
  output logic [DATA_WIDTH/8-1:0]   m_axi_WSTRB,
  output logic                      m_axi_WLAST,
  input  logic                      m_axi_WREADY,
  input  logic                      m_axi_BVALID,
  input  logic [1:0]                m_axi_BRESP,
  input  logic [ID_WIDTH-1:0]       m_axi_BID,
  output logic                      m_axi_BREADY
);

  localparam int          BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0]  AXI_SIZE   = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;
  localparam logic [31:0] MAX_OUT    = 32'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             ops_q, ops_d;
  logic [31:0]             stride_q, stride_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [31:0]             aw_cnt_q, aw_cnt_d;
  logic [31:0]             w_burst_cnt_q, w_burst_cnt_d;
  logic [31:0]             b_cnt_q, b_cnt_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    awvalid_q, awvalid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    start_acc_s;
  logic                    aw_hs_s;
  logic                    w_active_s;
  logic                    w_hs_s;
  logic                    w_last_s;
  logic                    b_acc_s;
  logic [ADDR_WIDTH-1:0]   addr_base_s;
  logic                    unused_s;

  assign start_acc_s = start_write & (state_q == S_IDLE);
  assign aw_hs_s     = awvalid_q & m_axi_AWREADY;
  assign w_active_s  = (state_q == S_RUN) & (w_burst_cnt_q < ops_q);
  assign w_last_s    = (beat_cnt_q == awlen_q);
  assign w_hs_s      = up_vld & m_axi_WREADY & w_active_s;
  // A B with nothing outstanding is a protocol violation and is dropped.
  assign b_acc_s     = m_axi_BVALID & (b_cnt_q != aw_cnt_q);
  assign addr_base_s = ADDR_WIDTH'({1'b0, 4'(ENGINE_ID), init_addr[27:0]});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_write && (write_ops != 32'd0)) state_d = S_RUN;
        else                                     state_d = S_IDLE;
      end
      S_RUN: begin
        if ((aw_cnt_q == ops_q) && (w_burst_cnt_q == ops_q)) state_d = S_DRAIN;
        else                                                 state_d = S_RUN;
      end
      S_DRAIN: begin
        if (b_cnt_q == ops_q) state_d = S_IDLE;
        else                  state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, registered below
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    case (state_q)
      S_IDLE:  done_d = start_write & (write_ops == 32'd0);
      S_DRAIN: done_d = (b_cnt_q == ops_q);
      default: done_d = 1'b0;
    endcase
  end

  // Config latch, counters and AW address generation
  always_comb begin
    ops_d         = ops_q;
    stride_d      = stride_q;
    awlen_d       = awlen_q;
    aw_cnt_d      = aw_cnt_q;
    w_burst_cnt_d = w_burst_cnt_q;
    b_cnt_d       = b_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    awaddr_d      = awaddr_q;
    if (start_acc_s) begin
      ops_d         = write_ops;
      stride_d      = stride;
      awlen_d       = 8'((mem_burst_size >> BEAT_SHIFT) - 16'd1);
      aw_cnt_d      = 32'd0;
      w_burst_cnt_d = 32'd0;
      b_cnt_d       = 32'd0;
      beat_cnt_d    = 8'd0;
      awaddr_d      = addr_base_s;
    end else begin
      aw_cnt_d = aw_cnt_q + 32'(aw_hs_s);
      b_cnt_d  = b_cnt_q + 32'(b_acc_s);
      if (aw_hs_s) awaddr_d = awaddr_q + ADDR_WIDTH'(stride_q);
      else         awaddr_d = awaddr_q;
      if (w_hs_s) begin
        if (w_last_s) begin
          beat_cnt_d    = 8'd0;
          w_burst_cnt_d = w_burst_cnt_q + 32'd1;
        end else begin
          beat_cnt_d    = beat_cnt_q + 8'd1;
        end
      end else begin
        beat_cnt_d = beat_cnt_q;
      end
    end
  end

  // AWVALID is computed from next-cycle counts so it never retracts before AWREADY
  always_comb begin
    if (awvalid_q && !m_axi_AWREADY) begin
      awvalid_d = 1'b1;
    end else begin
      awvalid_d = (state_d == S_RUN) && (aw_cnt_d < ops_d) &&
                  ((aw_cnt_d - b_cnt_d) < MAX_OUT);
    end
  end

`ifdef HBM_AUTO_WRITE_ERR_CHECK_EN
  // Sticky BRESP error, cleared by the next accepted start
  always_comb begin
    if (start_acc_s)                                   err_d = 1'b0;
    else if (m_axi_BVALID && (m_axi_BRESP != 2'b00))   err_d = 1'b1;
    else                                               err_d = err_q;
  end
  assign unused_s = ^{init_addr[ADDR_WIDTH-1:28], m_axi_BID};
`else
  assign err_d    = 1'b0;
  assign unused_s = ^{init_addr[ADDR_WIDTH-1:28], m_axi_BID, m_axi_BRESP};
`endif

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q         <= 32'd0;
      stride_q      <= 32'd0;
      awlen_q       <= 8'd0;
      aw_cnt_q      <= 32'd0;
      w_burst_cnt_q <= 32'd0;
      b_cnt_q       <= 32'd0;
      beat_cnt_q    <= 8'd0;
      awaddr_q      <= '0;
      awvalid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ops_q         <= ops_d;
      stride_q      <= stride_d;
      awlen_q       <= awlen_d;
      aw_cnt_q      <= aw_cnt_d;
      w_burst_cnt_q <= w_burst_cnt_d;
      b_cnt_q       <= b_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      awaddr_q      <= awaddr_d;
      awvalid_q     <= awvalid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

  assign m_axi_AWVALID  = awvalid_q;
  assign m_axi_AWADDR   = awaddr_q;
  assign m_axi_AWID     = '0;
  assign m_axi_AWLEN    = awlen_q;
  assign m_axi_AWSIZE   = AXI_SIZE;
  assign m_axi_AWBURST  = 2'b01;
  assign m_axi_AWLOCK   = 1'b0;
  assign m_axi_AWCACHE  = 4'b0000;
  assign m_axi_AWPROT   = 3'b010;
  assign m_axi_AWQOS    = 4'b0000;
  assign m_axi_AWREGION = 4'b0000;

  // W is a pure pass-through of the upstream stream
  assign m_axi_WVALID   = up_vld & w_active_s;
  assign m_axi_WDATA    = up_dat;
  assign m_axi_WSTRB    = {(DATA_WIDTH/8){1'b1}};
  assign m_axi_WLAST    = w_last_s & w_active_s;
  assign up_rdy         = m_axi_WREADY & w_active_s;

  assign m_axi_BREADY   = 1'b1;

endmodule
